// File: rtl/quad_root_arbiter_if.sv
// quad_root_arbiter_if: request, solver and result buses of the quad_root arbiter.
// The arbiter takes the slave view; the surrounding environment takes the master view.
interface quad_root_arbiter_if #(
  parameter int N_CH       = 4,
  parameter int CH_BITS    = 2,
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 8
);
  // requester side
  logic [N_CH*DIN_WIDTH-1:0] s_b;
  logic [N_CH*DIN_WIDTH-1:0] s_c;
  logic [N_CH-1:0]           s_valid;
  logic [N_CH-1:0]           s_ready;
  // solver side
  logic [DIN_WIDTH-1:0]      root_b;
  logic [DIN_WIDTH-1:0]      root_c;
  logic                      root_valid;
  logic [DOUT_WIDTH-1:0]     root_x1;
  logic [DOUT_WIDTH-1:0]     root_x2;
  logic                      root_dout_valid;
  // result side
  logic [DOUT_WIDTH-1:0]     m_x1;
  logic [DOUT_WIDTH-1:0]     m_x2;
  logic [CH_BITS-1:0]        m_ch;
  logic                      m_valid;
  logic                      m_complex;
  logic                      sync_err;

  modport master (
    output s_b, s_c, s_valid,
    input  s_ready,
    input  root_b, root_c, root_valid,
    output root_x1, root_x2, root_dout_valid,
    input  m_x1, m_x2, m_ch, m_valid, m_complex, sync_err
  );

  modport slave (
    input  s_b, s_c, s_valid,
    output s_ready,
    output root_b, root_c, root_valid,
    input  root_x1, root_x2, root_dout_valid,
    output m_x1, m_x2, m_ch, m_valid, m_complex, sync_err
  );
endinterface

// File: rtl/quad_root_arbiter.sv
// quad_root_arbiter: round-robin front end sharing one quad_root solver between
// N_CH requesters. Each issue's channel rides a fixed-latency tag line so the
// solver output can be returned tagged; a missing solver output marks the
// result complex, an untagged one raises sticky sync_err.
module quad_root_arbiter #(
  parameter int N_CH         = 4,
  parameter int CH_BITS      = 2,
  parameter int DIN_WIDTH    = 16,
  parameter int DOUT_WIDTH   = 8,
  parameter int ROOT_LATENCY = 9
) (
  input  logic               clk,
  input  logic               rst,
  quad_root_arbiter_if.slave bus
);

  localparam int IDX_BITS = CH_BITS + 1;
  localparam int CNT_BITS = $clog2(ROOT_LATENCY + 2);
  localparam logic [CNT_BITS-1:0] SUPPRESS_LOAD = CNT_BITS'(ROOT_LATENCY + 1);
  localparam logic [CH_BITS-1:0]  LAST_CH       = CH_BITS'(N_CH - 1);
  localparam logic [N_CH-1:0]     ONE_HOT0      = N_CH'(1);

  // arbitration
  logic [CH_BITS-1:0]    ptr_r;
  logic [IDX_BITS-1:0]   raw_s;
  logic [IDX_BITS-1:0]   cand_s;
  logic                  hit_s;
  logic                  found_s;
  logic [CH_BITS-1:0]    sel_s;
  logic [N_CH-1:0]       grant_s;
  logic                  xfer_s;
  logic [CH_BITS-1:0]    next_ptr_s;

  // issue registers
  logic [DIN_WIDTH-1:0]  root_b_r;
  logic [DIN_WIDTH-1:0]  root_c_r;
  logic                  root_valid_r;
  logic [CH_BITS-1:0]    root_ch_r;

  // tag line, index ROOT_LATENCY-1 is the head
  logic [ROOT_LATENCY-1:0]              tag_vld_r;
  logic [ROOT_LATENCY-1:0][CH_BITS-1:0] tag_ch_r;
  logic                                 head_vld_s;
  logic [CH_BITS-1:0]                   head_ch_s;

  // result registers and post-reset suppress window
  logic [CNT_BITS-1:0]   suppress_r;
  logic                  dout_seen_s;
  logic [DOUT_WIDTH-1:0] m_x1_r;
  logic [DOUT_WIDTH-1:0] m_x2_r;
  logic [CH_BITS-1:0]    m_ch_r;
  logic                  m_valid_r;
  logic                  m_complex_r;
  logic                  sync_err_r;

  // Round-robin pick: first requesting channel at or above ptr, wrapping at N_CH.
  always_comb begin
    raw_s   = '0;
    cand_s  = '0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    sel_s   = '0;
    for (int k = 0; k < N_CH; k++) begin
      raw_s   = {1'b0, ptr_r} + IDX_BITS'(k);
      cand_s  = (raw_s >= IDX_BITS'(N_CH)) ? (raw_s - IDX_BITS'(N_CH)) : raw_s;
      hit_s   = !found_s && bus.s_valid[cand_s[CH_BITS-1:0]];
      sel_s   = hit_s ? cand_s[CH_BITS-1:0] : sel_s;
      found_s = found_s | hit_s;
    end
    grant_s = found_s ? (ONE_HOT0 << sel_s) : '0;
  end

  assign bus.s_ready = rst ? '0 : grant_s;
  assign xfer_s      = found_s & ~rst;
  assign next_ptr_s  = (sel_s == LAST_CH) ? '0 : (sel_s + CH_BITS'(1));

  // Advance the pointer past the served channel and register the issue to the solver.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r        <= '0;
      root_b_r     <= '0;
      root_c_r     <= '0;
      root_valid_r <= 1'b0;
      root_ch_r    <= '0;
    end else if (xfer_s) begin
      ptr_r        <= next_ptr_s;
      root_b_r     <= bus.s_b[sel_s*DIN_WIDTH +: DIN_WIDTH];
      root_c_r     <= bus.s_c[sel_s*DIN_WIDTH +: DIN_WIDTH];
      root_valid_r <= 1'b1;
      root_ch_r    <= sel_s;
    end else begin
      root_valid_r <= 1'b0;
    end
  end

  assign bus.root_b     = root_b_r;
  assign bus.root_c     = root_c_r;
  assign bus.root_valid = root_valid_r;

  // Shift {valid, channel} of each cycle's issue so the head meets the solver output.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_r <= '0;
      tag_ch_r  <= '0;
    end else begin
      tag_vld_r <= {tag_vld_r[ROOT_LATENCY-2:0], root_valid_r};
      tag_ch_r  <= {tag_ch_r[ROOT_LATENCY-2:0], root_ch_r};
    end
  end

  assign head_vld_s  = tag_vld_r[ROOT_LATENCY-1];
  assign head_ch_s   = tag_ch_r[ROOT_LATENCY-1];
  // solver residue from before a reset is ignored until the window closes
  assign dout_seen_s = bus.root_dout_valid && (suppress_r == '0);

  // Retire the head: deliver the result, mark a dropped issue complex, or flag an untagged output.
  always_ff @(posedge clk) begin
    if (rst) begin
      suppress_r  <= SUPPRESS_LOAD;
      m_x1_r      <= '0;
      m_x2_r      <= '0;
      m_ch_r      <= '0;
      m_valid_r   <= 1'b0;
      m_complex_r <= 1'b0;
      sync_err_r  <= 1'b0;
    end else begin
      suppress_r <= (suppress_r != '0) ? (suppress_r - CNT_BITS'(1)) : suppress_r;
      if (head_vld_s) begin
        m_valid_r <= 1'b1;
        m_ch_r    <= head_ch_s;
        if (dout_seen_s) begin
          m_complex_r <= 1'b0;
          m_x1_r      <= bus.root_x1;
          m_x2_r      <= bus.root_x2;
        end else begin
          m_complex_r <= 1'b1;
          m_x1_r      <= '0;
          m_x2_r      <= '0;
        end
      end else begin
        m_valid_r   <= 1'b0;
        m_complex_r <= 1'b0;
        sync_err_r  <= sync_err_r | dout_seen_s;
      end
    end
  end

  assign bus.m_x1      = m_x1_r;
  assign bus.m_x2      = m_x2_r;
  assign bus.m_ch      = m_ch_r;
  assign bus.m_valid   = m_valid_r;
  assign bus.m_complex = m_complex_r;
  assign bus.sync_err  = sync_err_r;

endmodule

// File: tb/tb_quad_root_arbiter.sv
// tb_quad_root_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (expected-result queue keyed by due cycle), with a
// behavioural fixed-delay solver stub that can drop or inject outputs.
module tb_quad_root_arbiter;
  localparam int N_CH    = 4;
  localparam int CH_BITS = 2;
  localparam int DW      = 16;
  localparam int OW      = 8;
  localparam int LAT     = 9;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic inject_s = 1'b0;

  always #5 clk = ~clk;

  quad_root_arbiter_if #(.N_CH(N_CH), .CH_BITS(CH_BITS), .DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus ();

  quad_root_arbiter #(
    .N_CH(N_CH), .CH_BITS(CH_BITS), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .ROOT_LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- solver stub ----------------
  logic [LAT-1:0]         pipe_v = '0;
  logic [LAT-1:0][OW-1:0] pipe_x1;
  logic [LAT-1:0][OW-1:0] pipe_x2;
  bit                     drop_q[$];

  // fixed-delay stub: one drop flag per issue, inject adds an untagged output
  always @(posedge clk) begin
    pipe_v  <= {pipe_v[LAT-2:0],
                (bus.root_valid & ~(drop_q.size() > 0 && drop_q[0])) | inject_s};
    pipe_x1 <= {pipe_x1[LAT-2:0], bus.root_b[7:0] ^ bus.root_c[15:8]};
    pipe_x2 <= {pipe_x2[LAT-2:0], bus.root_b[15:8] + bus.root_c[7:0]};
    if (bus.root_valid && drop_q.size() > 0) void'(drop_q.pop_front());
  end

  assign bus.root_dout_valid = pipe_v[LAT-1];
  assign bus.root_x1         = pipe_x1[LAT-1];
  assign bus.root_x2         = pipe_x2[LAT-1];

  // ---------------- reference model state ----------------
  typedef struct {
    int          due;
    int          ch;
    logic [7:0]  x1;
    logic [7:0]  x2;
    bit          drop;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  int          cyc;
  int          m_ptr;
  int          last_rst;
  int          sync_due;
  logic [7:0]  exp_x1;
  logic [7:0]  exp_x2;
  int          exp_ch;
  bit          force_drop;
  bit          rand_drop;
  bit          req_v[N_CH];
  logic [15:0] req_b[N_CH];
  logic [15:0] req_c[N_CH];

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic arm(input int ch);
    if (!req_v[ch]) begin
      req_v[ch] = 1'b1;
      req_b[ch] = 16'($urandom);
      req_c[ch] = 16'($urandom);
    end
  endtask

  // one clock cycle: drive, check grant at negedge, check registered outputs after the edge
  task automatic step(input bit rst_v, input bit inj_v);
    int             g;
    logic [N_CH-1:0] er;
    exp_t           e;
    bit             mv;
    rst      = rst_v;
    inject_s = inj_v;
    for (int i = 0; i < N_CH; i++) begin
      bus.s_valid[i]          = req_v[i];
      bus.s_b[i*DW +: DW]     = req_b[i];
      bus.s_c[i*DW +: DW]     = req_c[i];
    end
    @(negedge clk);
    g  = -1;
    er = '0;
    if (!rst_v) begin
      for (int k = 0; k < N_CH; k++) begin
        int i = (m_ptr + k) % N_CH;
        if (g < 0 && req_v[i]) g = i;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("s_ready", bus.s_ready, er);
    if (g >= 0) begin
      e.due  = cyc + 2 + LAT;
      e.ch   = g;
      e.x1   = req_b[g][7:0] ^ req_c[g][15:8];
      e.x2   = req_b[g][15:8] + req_c[g][7:0];
      e.drop = force_drop || (rand_drop && $urandom_range(0, 7) == 0);
      force_drop = 1'b0;
      exp_q.push_back(e);
      drop_q.push_back(e.drop);
      grant_log.push_back(g);
      m_ptr  = (g + 1) % N_CH;
      req_v[g] = 1'b0;
    end
    // an untagged solver output lands LAT cycles after injection; flagged unless in the window
    if (inj_v && (cyc + LAT > last_rst + LAT + 1) && sync_due < 0) sync_due = cyc + LAT + 1;
    if (rst_v) begin
      exp_q.delete();
      m_ptr    = 0;
      last_rst = cyc;
      sync_due = -1;
      exp_x1   = 8'h00;
      exp_x2   = 8'h00;
      exp_ch   = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    mv = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e      = exp_q.pop_front();
      mv     = 1'b1;
      exp_ch = e.ch;
      exp_x1 = e.drop ? 8'h00 : e.x1;
      exp_x2 = e.drop ? 8'h00 : e.x2;
      chk("m_complex", bus.m_complex, e.drop);
    end
    chk("m_valid", bus.m_valid, mv);
    chk("m_ch", bus.m_ch, exp_ch);
    chk("m_x1", bus.m_x1, exp_x1);
    chk("m_x2", bus.m_x2, exp_x2);
    chk("sync_err", bus.sync_err, (sync_due >= 0 && cyc >= sync_due));
    if (rst_v) begin
      chk("rst_root_valid", bus.root_valid, 1'b0);
      chk("rst_root_b", bus.root_b, 16'h0000);
      chk("rst_root_c", bus.root_c, 16'h0000);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    bus.s_valid = '0;
    bus.s_b     = '0;
    bus.s_c     = '0;
    for (int i = 0; i < N_CH; i++) begin
      req_v[i] = 1'b0;
      req_b[i] = 16'h0000;
      req_c[i] = 16'h0000;
    end
    cyc = 0; m_ptr = 0; last_rst = -100; sync_due = -1;
    exp_x1 = 8'h00; exp_x2 = 8'h00; exp_ch = 0;
    force_drop = 1'b0; rand_drop = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // single request on ch2
    grant_log.delete();
    req_v[2] = 1'b1; req_b[2] = 16'hA000; req_c[2] = 16'h2000;
    step(1'b0, 1'b0);
    chk("t1_grant", (grant_log.size() == 1) ? grant_log[0] : -1, 2);
    chk("t1_root_valid", bus.root_valid, 1'b1);
    chk("t1_root_b", bus.root_b, 16'hA000);
    chk("t1_root_c", bus.root_c, 16'h2000);
    idle(12);

    // all four held: strict 0,1,2,3 rotation from reset
    step(1'b1, 1'b0);
    grant_log.delete();
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < N_CH; i++) arm(i);
      step(1'b0, 1'b0);
    end
    for (int k = 0; k < 12; k++)
      chk("t2_order", (grant_log.size() > k) ? grant_log[k] : -1, k % N_CH);
    idle(14);

    // ch1 and ch3 only, with ptr moved to 2
    arm(1);
    step(1'b0, 1'b0);
    grant_log.delete();
    for (int n = 0; n < 3; n++) begin
      arm(1); arm(3);
      step(1'b0, 1'b0);
    end
    chk("t3_g0", (grant_log.size() > 0) ? grant_log[0] : -1, 3);
    chk("t3_g1", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
    chk("t3_g2", (grant_log.size() > 2) ? grant_log[2] : -1, 3);
    idle(14);

    // second of three issues dropped by the solver
    arm(0); arm(1); arm(2);
    step(1'b0, 1'b0);
    force_drop = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    idle(14);

    // untagged solver output outside the suppress window
    step(1'b0, 1'b1);
    idle(11);
    chk("t5_sync_set", bus.sync_err, 1'b1);
    idle(5);
    chk("t5_sync_hold", bus.sync_err, 1'b1);

    // reset four cycles after three issues: stale results must vanish
    arm(0); arm(1); arm(2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b0);
    grant_log.delete();
    arm(3); arm(0);
    step(1'b0, 1'b0);
    chk("t6_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    idle(16);
    chk("t6_no_sync", bus.sync_err, 1'b0);

    // randomized traffic with random drops and one mid-stream reset
    rand_drop = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 1) == 1) arm(i);
      step((n == 200) ? 1'b1 : 1'b0, 1'b0);
    end
    rand_drop = 1'b0;
    idle(16);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
